// File: rtl/tlul_preload_ram.sv
// tlul_preload_ram: TL-UL single-port SRAM device with a preload port and a LOAD->RUN gate.
package tlul_pkg;
    localparam logic [2:0] PutFullData = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] Get = 3'd4;
    localparam logic [2:0] AccessAck = 3'd0;
    localparam logic [2:0] AccessAckData = 3'd1;
    localparam logic [15:0] TlDUserDefault = 16'h0000;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;
    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module tlul_preload_ram #(
    parameter int          Depth       = 2048,
    parameter logic [31:0] BaseAddr    = 32'h2000_0000,
    parameter int          Outstanding = 2,
    localparam int         AW          = $clog2(Depth)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  tlul_pkg::tl_h2d_t   tl_i,
    output tlul_pkg::tl_d2h_t   tl_o,
    input  logic                load_we_i,
    input  logic [AW-1:0]       load_waddr_i,
    input  logic [31:0]         load_wdata_i,
    input  logic [31:0]         load_wmask_i,
    input  logic                load_done_i,
    output logic                ready_o,
    output logic                load_viol_o
);
    typedef enum logic {LOAD, RUN} state_e;
    typedef struct packed {
        logic       get;
        logic [1:0] size;
        logic [7:0] source;
        logic       err;
    } meta_t;
    localparam logic [1:0] Last = 2'(Outstanding - 1);
    localparam logic [2:0] Full = 3'(Outstanding);
    logic [31:0] mem [Depth];
    meta_t       meta_q [4];
    logic [31:0] data_q [4];
    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [1:0]  wptr_q, rptr_q;
    logic        viol_q;
    logic [AW-1:0] idx;
    logic is_get, is_put, err, a_ready, hs, pop, unused_ok;
    assign idx = tl_i.a_address[AW+1:2];
    assign is_get = tl_i.a_opcode == tlul_pkg::Get;
    assign is_put = tl_i.a_opcode == tlul_pkg::PutFullData || tl_i.a_opcode == tlul_pkg::PutPartialData;
    // Range check on the upper address bits works because BaseAddr is Depth*4 aligned.
    assign err = (|tl_i.a_address[1:0]) || tl_i.a_address[31:AW+2] != BaseAddr[31:AW+2] ||
                 !(is_get || is_put) || tl_i.a_size > 2'd2;
    assign a_ready = state_q == RUN && cnt_q < Full;
    assign hs = tl_i.a_valid && a_ready;
    assign pop = cnt_q != 3'd0 && tl_i.d_ready;
    assign ready_o = state_q == RUN;
    assign load_viol_o = viol_q;
    assign unused_ok = ^{tl_i.a_param, tl_i.a_user};

    always_ff @(posedge clk_i) begin
        if (state_q == LOAD && load_we_i)
            mem[load_waddr_i] <= (mem[load_waddr_i] & ~load_wmask_i) | (load_wdata_i & load_wmask_i);
        if (hs && is_put && !err)
            for (int b = 0; b < 4; b++)
                if (tl_i.a_mask[b]) mem[idx][8*b +: 8] <= tl_i.a_data[8*b +: 8];
        if (hs) begin
            meta_q[wptr_q] <= '{get: is_get, size: tl_i.a_size, source: tl_i.a_source, err: err};
            data_q[wptr_q] <= !is_get ? 32'h0 : err ? 32'hFFFF_FFFF : mem[idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LOAD;
            cnt_q   <= 3'd0;
            wptr_q  <= 2'd0;
            rptr_q  <= 2'd0;
            viol_q  <= 1'b0;
        end else begin
            if (state_q == LOAD && load_done_i) state_q <= RUN;
            if (state_q == RUN && load_we_i) viol_q <= 1'b1;
            if (hs) wptr_q <= wptr_q == Last ? 2'd0 : wptr_q + 2'd1;
            if (pop) rptr_q <= rptr_q == Last ? 2'd0 : rptr_q + 2'd1;
            cnt_q <= cnt_q + 3'(hs) - 3'(pop);
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = a_ready;
        tl_o.d_valid  = cnt_q != 3'd0;
        tl_o.d_opcode = meta_q[rptr_q].get ? tlul_pkg::AccessAckData : tlul_pkg::AccessAck;
        tl_o.d_size   = meta_q[rptr_q].size;
        tl_o.d_source = meta_q[rptr_q].source;
        tl_o.d_error  = meta_q[rptr_q].err;
        tl_o.d_data   = data_q[rptr_q];
        tl_o.d_user   = tlul_pkg::TlDUserDefault;
    end
endmodule

// File: tb/tb_tlul_preload_ram.sv
// tb_tlul_preload_ram: directed stimulus with a queue scoreboard checked by a separate monitor.
module tb_tlul_preload_ram;
    localparam int Depth = 2048;
    localparam int AW = $clog2(Depth);
    localparam logic [31:0] Base = 32'h2000_0000;

    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  src;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic clk = 0, rst = 1;
    tlul_pkg::tl_h2d_t tl;
    tlul_pkg::tl_d2h_t tlo;
    logic load_we = 0, load_done = 0, ready, viol;
    logic [AW-1:0] load_waddr = '0;
    logic [31:0] load_wdata = '0, load_wmask = '0;
    int checks = 0, passes = 0;
    rsp_t exp_q[$];
    rsp_t held, e;
    logic hold_v = 0;

    tlul_preload_ram #(.Depth(Depth), .BaseAddr(Base), .Outstanding(2)) dut (
        .clk_i(clk), .rst_i(rst), .tl_i(tl), .tl_o(tlo),
        .load_we_i(load_we), .load_waddr_i(load_waddr), .load_wdata_i(load_wdata),
        .load_wmask_i(load_wmask), .load_done_i(load_done),
        .ready_o(ready), .load_viol_o(viol)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic rsp_t cur();
        return {tlo.d_opcode, tlo.d_size, tlo.d_source, tlo.d_error, tlo.d_data};
    endfunction

    always @(negedge clk) begin
        if (rst) hold_v = 0;
        else begin
            if (hold_v) chk("hold_stable", {tlo.d_valid, cur()}, {1'b1, held});
            if (tlo.d_valid && tl.d_ready) begin
                if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("rsp", {cur(), tlo.d_param, tlo.d_sink}, {e, 3'b0, 1'b0});
                end
                hold_v = 0;
            end else begin
                hold_v = tlo.d_valid;
                held = cur();
            end
        end
    end

    task automatic load(input logic [AW-1:0] a, input logic [31:0] d, input logic [31:0] m, input logic done);
        @(negedge clk);
        load_we = 1; load_waddr = a; load_wdata = d; load_wmask = m; load_done = done;
        @(posedge clk);
        #1 load_we = 0; load_done = 0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input logic [7:0] src, input logic [1:0] size,
                         input logic exp_err, input logic [31:0] exp_data);
        int n;
        @(negedge clk);
        tl.a_valid = 1; tl.a_opcode = op; tl.a_address = addr; tl.a_mask = mask;
        tl.a_data = data; tl.a_source = src; tl.a_size = size;
        for (n = 0; n < 50 && !tlo.a_ready; n++) @(negedge clk);
        if (!tlo.a_ready) begin
            chk("a_ready_timeout", 0, 1);
            tl.a_valid = 0;
            return;
        end
        @(posedge clk);
        exp_q.push_back('{op: (op == 3'd4) ? 3'd1 : 3'd0, size: size, src: src, err: exp_err, data: exp_data});
        #1 tl.a_valid = 0;
    endtask

    task automatic get(input logic [31:0] addr, input logic [7:0] src, input logic exp_err, input logic [31:0] exp_data);
        issue(3'd4, addr, 4'hF, 32'h0, src, 2'd2, exp_err, exp_data);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tl = '0;
        tl.d_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {tlo.a_ready, tlo.d_valid, ready, viol}, 4'b0000);
        @(posedge clk);
        #1 rst = 0;
        load(5, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0);
        load(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        load(3, 32'h0000_0000, 32'h0000_FF00, 0);
        load(7, 32'h0, 32'hFFFF_FFFF, 0);
        load(8, 32'h0, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        chk("load_gate", {tlo.a_ready, ready}, 2'b00);
        load(9, 32'h1234_5678, 32'hFFFF_FFFF, 1);
        @(negedge clk);
        chk("enter_run", {tlo.a_ready, ready}, 2'b11);

        get(Base + 32'h14, 8'h01, 0, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("min_latency", tlo.d_valid, 1);
        get(Base + 32'h0C, 8'h02, 0, 32'hFFFF_00FF);
        get(Base + 32'h24, 8'h03, 0, 32'h1234_5678);
        issue(3'd1, Base + 32'h1C, 4'b0010, 32'h0000_AB00, 8'h04, 2'd2, 0, 32'h0);
        get(Base + 32'h1C, 8'h05, 0, 32'h0000_AB00);
        issue(3'd0, Base + 32'h20, 4'hF, 32'hCAFE_F00D, 8'h06, 2'd2, 0, 32'h0);
        get(Base + 32'h20, 8'h07, 0, 32'hCAFE_F00D);
        drain();

        get(Base + Depth * 4, 8'h10, 1, 32'hFFFF_FFFF);
        get(Base + 32'h2, 8'h11, 1, 32'hFFFF_FFFF);
        issue(3'd5, Base + 32'h14, 4'hF, 32'h0, 8'h12, 2'd2, 1, 32'h0);
        issue(3'd4, Base + 32'h14, 4'hF, 32'h0, 8'h13, 2'd3, 1, 32'hFFFF_FFFF);
        issue(3'd0, Base + 32'h16, 4'hF, 32'h0, 8'h14, 2'd2, 1, 32'h0);
        issue(3'd0, Base - 32'h4, 4'hF, 32'h0, 8'h15, 2'd2, 1, 32'h0);
        get(Base + 32'h14, 8'h16, 0, 32'hDEAD_BEEF);
        drain();

        @(posedge clk);
        #1 tl.d_ready = 0;
        fork
            begin
                get(Base + 32'h14, 8'h21, 0, 32'hDEAD_BEEF);
                get(Base + 32'h0C, 8'h22, 0, 32'hFFFF_00FF);
                get(Base + 32'h1C, 8'h23, 0, 32'h0000_AB00);
            end
            begin
                repeat (5) @(negedge clk);
                chk("backpressure_a_ready", {tlo.a_ready, tlo.d_valid}, 2'b01);
                @(posedge clk);
                #1 tl.d_ready = 1;
            end
        join
        drain();

        @(negedge clk);
        load_we = 1; load_waddr = 5; load_wdata = 32'h0; load_wmask = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 load_we = 0;
        @(negedge clk);
        chk("load_viol", {viol, ready}, 2'b11);
        get(Base + 32'h14, 8'h30, 0, 32'hDEAD_BEEF);
        drain();

        @(posedge clk);
        #1 tl.d_ready = 0;
        get(Base + 32'h14, 8'h40, 0, 32'hDEAD_BEEF);
        get(Base + 32'h0C, 8'h41, 0, 32'hFFFF_00FF);
        @(negedge clk);
        chk("queued_before_reset", {tlo.d_valid, tlo.a_ready}, 2'b10);
        @(posedge clk);
        #1 rst = 1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("after_reset", {tlo.d_valid, ready, viol, tlo.a_ready}, 4'b0000);
        #1 rst = 0;
        tl.d_ready = 1;
        repeat (2) @(negedge clk);
        chk("no_stale_rsp", {tlo.d_valid, ready}, 2'b00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/tlul_preload_ram.md
Name: tlul_preload_ram

Overview:
- Parametrised TL-UL single-port SRAM device. Generalises the fixed 2K-word instruction memory into a reusable block for both instruction and data memory.
- Adds a configurable depth, base address and response queue depth.
- Adds a bench/boot preload port with an explicit LOAD→RUN phase gate, plus TL-UL error responses.
- Sits on a crossbar device port, e.g. as the instruction memory at 0x2000_0000.

Parameters:
- Depth, 2048: number of 32-bit words; power of two, minimum 16. AW = $clog2(Depth).
- BaseAddr, 32'h2000_0000: byte base address; must be aligned to Depth*4.
- Outstanding, 2: response FIFO depth, range 1..4.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- tl_i  in  tlul_pkg::tl_h2d_t  TL-UL A channel and d_ready.
- tl_o  out  tlul_pkg::tl_d2h_t  TL-UL D channel and a_ready.
- load_we_i  in  1  preload write strobe.
- load_waddr_i  in  AW  preload word address.
- load_wdata_i  in  32  preload data.
- load_wmask_i  in  32  preload bit mask (1 = write this bit).
- load_done_i  in  1  single-cycle pulse that ends preload.
- ready_o  out  1  high in RUN.
- load_viol_o  out  1  sticky; set by load_we_i asserted in RUN.

Behaviour:
- Reset (synchronous, active-high):
  - state=LOAD; FIFO empty; a_ready=0; d_valid=0; ready_o=0; load_viol_o=0.
  - RAM contents are not reset.
  - Reset mid-transaction drops all queued responses.
- State machine:
  - LOAD→RUN on the cycle after load_done_i=1 is sampled.
  - RUN is held until reset; load_done_i is ignored in RUN.
- LOAD state:
  - a_ready=0.
  - load_we_i=1 writes mem[load_waddr_i] = (old & ~wmask) | (wdata & wmask). One write per cycle, committed at the clock edge.
  - load_we_i and load_done_i in the same cycle: the write commits, then the block enters RUN.
- RUN state:
  - load_we_i is ignored and sets load_viol_o.
  - a_ready = (fifo_count < Outstanding). It is not combinationally dependent on a_valid.
- A-channel handshake (a_valid & a_ready): classify the request.
  - Error if any of:
    - a_address[1:0] != 0;
    - address outside [BaseAddr, BaseAddr+Depth*4);
    - a_opcode not Get(4), PutFullData(0) or PutPartialData(1);
    - a_size > 2.
  - Get with no error: read mem[a_address[AW+1:2]]; the data is available in the cycle after the handshake.
  - Put with no error: byte-write using a_mask[3:0], committed at the handshake edge. A Get accepted in a later cycle returns the new data.
  - Error requests never touch memory.
- Response FIFO:
  - Entries hold {opcode, size, source, error, data}. Reads are captured when the RAM output is valid.
  - d_opcode is AccessAckData(1) for Get and AccessAck(0) for Put, including on error.
  - d_size and d_source echo the request.
  - d_param=0; d_sink=0; d_error=1 only on error.
  - d_data = read data for a good Get, 32'hFFFF_FFFF for an errored Get, 0 for Put.
  - d_user driven to the tlul_pkg default response value; a_user ignored.
- D channel:
  - Minimum latency: handshake at cycle N → d_valid at N+1.
  - d_valid and all d_* fields are held stable until d_ready.
  - Responses are returned strictly in request order.
- FIFO push and pop in the same cycle: count is unchanged. At count==Outstanding with a pop, a_ready stays 0 that cycle (no bypass).
- Address wrap is impossible: the range check precedes indexing.

Test Plan:
- Preload then read:
  - Stimulus: in LOAD, write addr 5 = 32'hDEAD_BEEF with mask all-ones, pulse load_done_i; then Get at BaseAddr+0x14.
  - Required: a_ready=0 before RUN, ready_o=1 one cycle after the done pulse, d_data=32'hDEAD_BEEF, d_opcode=1, d_error=0.
- Masked preload:
  - Stimulus: write 32'hFFFF_FFFF to addr 3, then 32'h0 with wmask 32'h0000_FF00.
  - Required: a Get of addr 3 returns 32'hFFFF_00FF.
- Partial Put then Get:
  - Stimulus: PutPartialData a_mask=4'b0010, data 32'h0000_AB00 to a word holding 0; then Get of the same word.
  - Required: AccessAck then data 32'h0000_AB00.
- Errors:
  - Stimulus: Get at BaseAddr+Depth*4, Get at BaseAddr+2, and opcode 5.
  - Required: each returns d_error=1, Get data 32'hFFFF_FFFF, memory unchanged.
- Backpressure:
  - Stimulus: Outstanding=2, hold d_ready=0, issue 3 back-to-back Gets.
  - Required: a_ready drops after 2 accepts; responses are held stable; releasing d_ready drains them in order with correct d_source values.
- Violation and reset:
  - Stimulus: load_we_i in RUN; then assert rst_i with 2 responses queued.
  - Required: load_viol_o=1 and memory unchanged; after reset d_valid=0, ready_o=0, load_viol_o=0.
